wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the GPR, HI, LO and data ports.
REQ-002 Parameter ADDR_W, default 5, SHALL set the GPR address width (2^ADDR_W registers).
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 wb_dest_addr  input  ADDR_W  SHALL be the writeback destination GPR index.
REQ-006 wb_wreg  input  1  SHALL be the GPR write enable from the writeback stage.
REQ-007 wb_dest_data  input  DATA_W  SHALL be the GPR write data.
REQ-008 wb_hi / wb_lo  input  DATA_W each  SHALL be the HI/LO write data.
REQ-009 wb_whilo  input  1  SHALL be the joint HI/LO write enable.
REQ-010 re1 / re2  input  1 each  SHALL be the read enables for read ports 1 and 2.
REQ-011 raddr1 / raddr2  input  ADDR_W each  SHALL be the read addresses.
REQ-012 rdata1 / rdata2  output  DATA_W each  SHALL be the combinational read data.
REQ-013 hi_o / lo_o  output  DATA_W each  SHALL be the current (bypassed) HI/LO values.
REQ-014 wb_count  output  32  SHALL be the count of committed writebacks.

Function
REQ-015 GPR array: 2^ADDR_W x DATA_W; HI and LO: one DATA_W register each.
REQ-016 GPR write: rising edge with rst=0, wb_wreg=1, wb_dest_addr!=0 -> gpr[wb_dest_addr] <= wb_dest_data; value in array from next cycle.
REQ-017 Write to address 0 SHALL be discarded; gpr[0] reads 0 always.
REQ-018 HI/LO write: rising edge with rst=0, wb_whilo=1 -> HI <= wb_hi and LO <= wb_lo in the same edge; never one without the other.
REQ-019 Read port n priority (first match wins): rst=1 -> 0; ren=0 -> 0; raddrn=0 -> 0; wb_wreg=1 and raddrn==wb_dest_addr -> wb_dest_data (same-cycle bypass); else gpr[raddrn].
REQ-020 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-021 hi_o/lo_o: rst=1 -> 0; wb_whilo=1 -> wb_hi/wb_lo (bypass); else stored HI/LO.
REQ-022 Read path latency SHALL be zero cycles (purely combinational from inputs and stored state).
REQ-023 GPR write and HI/LO write in the same cycle SHALL both commit.
REQ-024 wb_count SHALL increment by exactly 1 on each edge where rst=0 and ((wb_wreg=1 and wb_dest_addr!=0) or wb_whilo=1); simultaneous GPR and HI/LO writes count once.
REQ-025 wb_count SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-026 X on wb_dest_addr while wb_wreg=0 SHALL have no effect on state.

Reset
REQ-027 Edge with rst=1 SHALL clear all GPRs, HI, LO and wb_count to 0 and SHALL block all writes that cycle.
REQ-028 While rst=1, rdata1, rdata2, hi_o, lo_o SHALL read 0 regardless of other inputs.
REQ-029 rst asserted mid-stream SHALL discard any write presented in that cycle; first write accepted on the first edge with rst=0.

Verification
REQ-030 Reset then wb_wreg=1, addr=5, data=0x12345678; same cycle re1=1, raddr1=5 -> rdata1=0x12345678 (bypass); next cycle with wb_wreg=0 -> rdata1=0x12345678 (array), wb_count=1.
REQ-031 wb_wreg=1, addr=0, data=0xFFFFFFFF; re1=1, raddr1=0 -> rdata1=0 that cycle and after; wb_count unchanged.
REQ-032 gpr[3]=0xA, gpr[4]=0xB; re1=1 raddr1=3, re2=0 raddr2=4 -> rdata1=0xA, rdata2=0; re2=1 -> rdata2=0xB.
REQ-033 wb_whilo=1, wb_hi=0xDEAD0000, wb_lo=0x0000BEEF with wb_wreg=1 addr=7 -> hi_o/lo_o show values same cycle; next edge both stored; wb_count +1 (not +2).
REQ-034 Preload wb_count=0xFFFFFFFF via writes (or force), one more commit -> wb_count=0.
REQ-035 gpr[9]=0x55; assert rst=1 for one cycle with wb_wreg=1 addr=9 data=0x77 -> rdata1=0 during reset, gpr[9]=0 after, wb_count=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback register file: GPR array with zero register, joint HI/LO pair,
// same-cycle writeback bypass on every read path, and a committed-writeback counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_dest_addr,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_dest_data,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [31:0]       wb_count
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [31:0]       count_q, count_d;
  logic              gpr_we, commit;

  assign gpr_we  = wb_wreg && (wb_dest_addr != '0);
  assign commit  = gpr_we || wb_whilo;
  // Counter register is reloaded every edge so the next value always derives from its current contents
  assign count_d = commit ? count_q + 32'd1 : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      if (gpr_we) begin
        gpr_q[wb_dest_addr] <= wb_dest_data;
      end
      if (wb_whilo) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (wb_wreg && (raddr1 == wb_dest_addr)) begin
        rdata1 = wb_dest_data;
      end else begin
        rdata1 = gpr_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (wb_wreg && (raddr2 == wb_dest_addr)) begin
        rdata2 = wb_dest_data;
      end else begin
        rdata2 = gpr_q[raddr2];
      end
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      hi_o = wb_whilo ? wb_hi : hi_q;
      lo_o = wb_whilo ? wb_lo : lo_q;
    end
  end

  assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic checked
// against an array/counter reference model of the register file.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_dest_addr;
  logic        wb_wreg;
  logic [31:0] wb_dest_data;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, wb_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] mg [32];
  logic [31:0] mhi, mlo, mcnt;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_dest_addr (wb_dest_addr),
    .wb_wreg      (wb_wreg),
    .wb_dest_data (wb_dest_data),
    .wb_hi        (wb_hi),
    .wb_lo        (wb_lo),
    .wb_whilo     (wb_whilo),
    .re1          (re1),
    .re2          (re2),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .wb_count     (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst) return 32'd0;
    if (!re) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (wb_wreg && a == wb_dest_addr) return wb_dest_data;
    return mg[a];
  endfunction

  // One clock edge; the reference model absorbs whatever the inputs present.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mg[i] = 32'd0;
      mhi = 32'd0; mlo = 32'd0; mcnt = 32'd0;
    end else begin
      if (wb_wreg && wb_dest_addr != 5'd0) mg[wb_dest_addr] = wb_dest_data;
      if (wb_whilo) begin mhi = wb_hi; mlo = wb_lo; end
      if ((wb_wreg && wb_dest_addr != 5'd0) || wb_whilo) mcnt = mcnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wb_wreg = 1'b0; wb_whilo = 1'b0; re1 = 1'b0; re2 = 1'b0;
    wb_dest_addr = 5'd0; wb_dest_data = 32'd0; wb_hi = 32'd0; wb_lo = 32'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; wb_wreg = 1'b1; wb_dest_addr = 5'd3; wb_dest_data = $urandom;
    wb_whilo = 1'b1; wb_hi = $urandom; wb_lo = $urandom;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    total++; if (rdata2 !== 32'd0) begin bad++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
    total++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
    step();
    step();
    total++; if (wb_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=0", wb_count); end
    idle(); re1 = 1'b1; raddr1 = 5'd3; #1;
    total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL reset_blocks_write got=%h exp=0", rdata1); end
  endtask

  task automatic test_bypass();
    idle();
    wb_wreg = 1'b1; wb_dest_addr = 5'd5; wb_dest_data = 32'h1234_5678;
    re1 = 1'b1; raddr1 = 5'd5; #1;
    total++; if (rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=12345678", rdata1); end
    step();
    wb_wreg = 1'b0; #1;
    total++; if (rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_array got=%h exp=12345678", rdata1); end
    total++; if (wb_count !== 32'd1) begin bad++; $display("FAIL bypass_count got=%h exp=1", wb_count); end
  endtask

  task automatic test_zero_reg();
    idle();
    wb_wreg = 1'b1; wb_dest_addr = 5'd0; wb_dest_data = 32'hFFFF_FFFF;
    re1 = 1'b1; raddr1 = 5'd0; #1;
    total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL zero_same_cycle got=%h exp=0", rdata1); end
    step();
    wb_wreg = 1'b0; #1;
    total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL zero_after got=%h exp=0", rdata1); end
    total++; if (wb_count !== 32'd1) begin bad++; $display("FAIL zero_count got=%h exp=1", wb_count); end
  endtask

  task automatic test_read_enable();
    idle();
    wb_wreg = 1'b1; wb_dest_addr = 5'd3; wb_dest_data = 32'hA; step();
    wb_dest_addr = 5'd4; wb_dest_data = 32'hB; step();
    idle();
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b0; raddr2 = 5'd4; #1;
    total++; if (rdata1 !== 32'hA) begin bad++; $display("FAIL ren_port1 got=%h exp=a", rdata1); end
    total++; if (rdata2 !== 32'd0) begin bad++; $display("FAIL ren_port2_off got=%h exp=0", rdata2); end
    re2 = 1'b1; #1;
    total++; if (rdata2 !== 32'hB) begin bad++; $display("FAIL ren_port2_on got=%h exp=b", rdata2); end
    raddr2 = 5'd3; #1;
    total++; if (rdata2 !== rdata1 || rdata2 !== 32'hA) begin bad++; $display("FAIL same_addr got=%h/%h exp=a/a", rdata1, rdata2); end
    total++; if (wb_count !== 32'd3) begin bad++; $display("FAIL ren_count got=%h exp=3", wb_count); end
  endtask

  task automatic test_hilo();
    logic [31:0] d;
    idle();
    d = $urandom;
    wb_whilo = 1'b1; wb_hi = 32'hDEAD_0000; wb_lo = 32'h0000_BEEF;
    wb_wreg = 1'b1; wb_dest_addr = 5'd7; wb_dest_data = d; #1;
    total++; if (hi_o !== 32'hDEAD_0000 || lo_o !== 32'h0000_BEEF) begin bad++; $display("FAIL hilo_bypass got=%h/%h exp=dead0000/0000beef", hi_o, lo_o); end
    step();
    idle(); wb_hi = 32'h1111_1111; wb_lo = 32'h2222_2222; re1 = 1'b1; raddr1 = 5'd7; #1;
    total++; if (hi_o !== 32'hDEAD_0000 || lo_o !== 32'h0000_BEEF) begin bad++; $display("FAIL hilo_stored got=%h/%h exp=dead0000/0000beef", hi_o, lo_o); end
    total++; if (rdata1 !== d) begin bad++; $display("FAIL hilo_gpr_commit got=%h exp=%h", rdata1, d); end
    total++; if (wb_count !== 32'd4) begin bad++; $display("FAIL hilo_count got=%h exp=4", wb_count); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, eh, el;
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      wb_wreg      = $urandom_range(0, 1);
      wb_whilo     = ($urandom_range(0, 3) == 0);
      wb_dest_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wb_dest_data = $urandom;
      wb_hi        = $urandom;
      wb_lo        = $urandom;
      re1          = ($urandom_range(0, 4) != 0);
      re2          = ($urandom_range(0, 4) != 0);
      raddr1       = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      raddr2       = ($urandom_range(0, 5) == 0) ? raddr1 : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) raddr1 = wb_dest_addr;
      #1;
      e1 = exp_rd(re1, raddr1);
      e2 = exp_rd(re2, raddr2);
      eh = rst ? 32'd0 : (wb_whilo ? wb_hi : mhi);
      el = rst ? 32'd0 : (wb_whilo ? wb_lo : mlo);
      total++; if (rdata1 !== e1) begin bad++; $display("FAIL rand_rdata1 n=%0d a=%0d got=%h exp=%h", n, raddr1, rdata1, e1); end
      total++; if (rdata2 !== e2) begin bad++; $display("FAIL rand_rdata2 n=%0d a=%0d got=%h exp=%h", n, raddr2, rdata2, e2); end
      total++; if (hi_o !== eh || lo_o !== el) begin bad++; $display("FAIL rand_hilo n=%0d got=%h/%h exp=%h/%h", n, hi_o, lo_o, eh, el); end
      step();
      total++; if (wb_count !== mcnt) begin bad++; $display("FAIL rand_count n=%0d got=%h exp=%h", n, wb_count, mcnt); end
    end
    idle();
  endtask

  task automatic test_wrap();
    idle();
    force dut.count_q = 32'hFFFF_FFFF;
    step();
    release dut.count_q;
    mcnt = 32'hFFFF_FFFF;
    #1;
    total++; if (wb_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", wb_count); end
    wb_wreg = 1'b1; wb_dest_addr = 5'($urandom_range(1, 31)); wb_dest_data = $urandom;
    step();
    total++; if (wb_count !== 32'd0) begin bad++; $display("FAIL wrap_count got=%h exp=0", wb_count); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    wb_wreg = 1'b1; wb_dest_addr = 5'd9; wb_dest_data = 32'h55; step();
    idle(); re1 = 1'b1; raddr1 = 5'd9; #1;
    total++; if (rdata1 !== 32'h55) begin bad++; $display("FAIL midrst_preload got=%h exp=55", rdata1); end
    rst = 1'b1; wb_wreg = 1'b1; wb_dest_addr = 5'd9; wb_dest_data = 32'h77; #1;
    total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL midrst_during got=%h exp=0", rdata1); end
    step();
    rst = 1'b0; wb_wreg = 1'b0; #1;
    total++; if (rdata1 !== 32'd0) begin bad++; $display("FAIL midrst_after got=%h exp=0", rdata1); end
    total++; if (wb_count !== 32'd0) begin bad++; $display("FAIL midrst_count got=%h exp=0", wb_count); end
    wb_wreg = 1'b1; wb_dest_data = 32'h99; step();
    wb_wreg = 1'b0; #1;
    total++; if (rdata1 !== 32'h99 || wb_count !== 32'd1) begin bad++; $display("FAIL midrst_first_write got=%h/%h exp=99/1", rdata1, wb_count); end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mg[i] = 32'd0;
    mhi = 32'd0; mlo = 32'd0; mcnt = 32'd0;
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_read_enable();
    test_hilo();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
